// File: rtl/rsa_pkg.sv
// Shared types and address map for the RSA register bank / sequencer.
package rsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_ABORT
    } state_t;

    localparam int ST_IRQ     = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_ABORTED = 3;
    localparam int ST_OVERRUN = 4;
    localparam int ST_WR_ERR  = 5;

    localparam int CTRL_START   = 0;
    localparam int CTRL_STOP    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_IRQ_CLR = 3;

    localparam int ADDR_STATUS = 0;
    localparam int ADDR_CTRL   = 1;

    // Operand blocks follow STATUS/CTRL in the order P, E, M, Const, C.
    function automatic int blk_base(int ob, int idx);
        return 2 + idx * ob;
    endfunction

    function automatic int p_base(int ob);
        return blk_base(ob, 0);
    endfunction

    function automatic int e_base(int ob);
        return blk_base(ob, 1);
    endfunction

    function automatic int m_base(int ob);
        return blk_base(ob, 2);
    endfunction

    function automatic int const_base(int ob);
        return blk_base(ob, 3);
    endfunction

    function automatic int c_base(int ob);
        return blk_base(ob, 4);
    endfunction

endpackage

// File: rtl/rsa_regbank_ctrl_if.sv
// Register access bus between the SPI register slave and the bank.
interface rsa_regbank_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int REG_W  = 8
);
    logic [ADDR_W-1:0] reg_addr;
    logic [REG_W-1:0]  reg_wdata;
    logic              reg_wr;
    logic [REG_W-1:0]  reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_wr,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_wr,
        output reg_rdata
    );
endinterface

// File: rtl/rsa_regbank_ctrl_sync_edge_det.sv
// Two-flop synchroniser with a registered rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/rsa_regbank_ctrl.sv
// Operand/result register bank and load/run/capture/abort sequencer
// for the external RSA modular-exponentiation engine.
module rsa_regbank_ctrl
    import rsa_pkg::*;
#(
    parameter int REG_W    = 8,
    parameter int ADDR_W   = 5,
    parameter int OP_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    rsa_regbank_ctrl_if.slave           bus,
    input  logic                        start_pin,
    output logic                        eng_en,
    output logic                        eng_clr,
    input  logic                        eng_eoc,
    input  logic [OP_BYTES*REG_W-1:0]   eng_c,
    output logic [OP_BYTES*REG_W-1:0]   op_p,
    output logic [OP_BYTES*REG_W-1:0]   op_e,
    output logic [OP_BYTES*REG_W-1:0]   op_m,
    output logic [OP_BYTES*REG_W-1:0]   op_const,
    output logic                        busy,
    output logic                        irq
);
    localparam int OP_W   = OP_BYTES * REG_W;
    localparam int PB     = p_base(OP_BYTES);
    localparam int EB     = e_base(OP_BYTES);
    localparam int MB     = m_base(OP_BYTES);
    localparam int KB     = const_base(OP_BYTES);
    localparam int CB     = c_base(OP_BYTES);

    state_t            state_q, state_d;
    logic              stop_pend_q, stop_pend_d;
    logic [OP_W-1:0]   op_c;
    logic              done_q, aborted_q, overrun_q, wr_err_q, irq_en_q;
    logic              done_d, aborted_d, overrun_d, wr_err_d, irq_en_d, irq_d;
    logic              start_evt, ctrl_wr, stop, irq_clr, start_req, idle;
    logic              op_hit, op_wr;
    logic [REG_W-1:0]  status;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (start_pin),
        .pulse (start_evt)
    );

    assign ctrl_wr   = bus.reg_wr && (bus.reg_addr == ADDR_W'(ADDR_CTRL));
    assign stop      = ctrl_wr & bus.reg_wdata[CTRL_STOP];
    assign irq_clr   = ctrl_wr & bus.reg_wdata[CTRL_IRQ_CLR];
    // STOP in the same write suppresses START.
    assign start_req = (ctrl_wr & bus.reg_wdata[CTRL_START] & ~stop) | start_evt;
    assign idle      = (state_q == S_IDLE);
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN)
                    || (state_q == S_CAPTURE);
    assign eng_en    = (state_q == S_RUN);
    assign eng_clr   = rst || (state_q == S_LOAD) || (state_q == S_ABORT);
    assign op_hit    = (int'(bus.reg_addr) >= PB) && (int'(bus.reg_addr) < CB);
    assign op_wr     = bus.reg_wr & ~busy;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = 1'b0;
        unique case (state_q)
            S_IDLE:    if (start_req) state_d = S_LOAD;
            S_LOAD: begin
                state_d     = S_RUN;
                stop_pend_d = stop;
            end
            S_RUN: begin
                if (eng_eoc)                  state_d = S_CAPTURE;
                else if (stop || stop_pend_q) state_d = S_ABORT;
            end
            S_CAPTURE: state_d = S_IDLE;
            S_ABORT:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Set events take priority over IRQ_CLR.
    always_comb begin
        done_d    = done_q;
        aborted_d = aborted_q;
        if (irq_clr || (start_req && idle)) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        if (state_q == S_CAPTURE) done_d    = 1'b1;
        if (state_q == S_ABORT)   aborted_d = 1'b1;
        overrun_d = (start_req && !idle) ? 1'b1
                  : irq_clr ? 1'b0 : overrun_q;
        wr_err_d  = (bus.reg_wr && busy && op_hit) ? 1'b1
                  : irq_clr ? 1'b0 : wr_err_q;
        irq_en_d  = ctrl_wr ? bus.reg_wdata[CTRL_IRQ_EN] : irq_en_q;
        irq_d     = irq_en_d & (done_d | aborted_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            overrun_q   <= 1'b0;
            wr_err_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            overrun_q   <= overrun_d;
            wr_err_q    <= wr_err_d;
            irq_en_q    <= irq_en_d;
            irq         <= irq_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_p     <= '0;
            op_e     <= '0;
            op_m     <= '0;
            op_const <= '0;
            op_c     <= '0;
        end else begin
            for (int i = 0; i < OP_BYTES; i++) begin
                if (op_wr && bus.reg_addr == ADDR_W'(PB + i))
                    op_p[i*REG_W +: REG_W] <= bus.reg_wdata;
                if (op_wr && bus.reg_addr == ADDR_W'(EB + i))
                    op_e[i*REG_W +: REG_W] <= bus.reg_wdata;
                if (op_wr && bus.reg_addr == ADDR_W'(MB + i))
                    op_m[i*REG_W +: REG_W] <= bus.reg_wdata;
                if (op_wr && bus.reg_addr == ADDR_W'(KB + i))
                    op_const[i*REG_W +: REG_W] <= bus.reg_wdata;
            end
            if (state_q == S_CAPTURE) op_c <= eng_c;
        end
    end

    always_comb begin
        status             = '0;
        status[ST_IRQ]     = irq;
        status[ST_DONE]    = done_q;
        status[ST_BUSY]    = busy;
        status[ST_ABORTED] = aborted_q;
        status[ST_OVERRUN] = overrun_q;
        status[ST_WR_ERR]  = wr_err_q;
    end

    always_comb begin
        bus.reg_rdata = '0;
        if (bus.reg_addr == ADDR_W'(ADDR_STATUS))
            bus.reg_rdata = status;
        if (bus.reg_addr == ADDR_W'(ADDR_CTRL))
            bus.reg_rdata[CTRL_IRQ_EN] = irq_en_q;
        for (int i = 0; i < OP_BYTES; i++) begin
            if (bus.reg_addr == ADDR_W'(PB + i))
                bus.reg_rdata = op_p[i*REG_W +: REG_W];
            if (bus.reg_addr == ADDR_W'(EB + i))
                bus.reg_rdata = op_e[i*REG_W +: REG_W];
            if (bus.reg_addr == ADDR_W'(MB + i))
                bus.reg_rdata = op_m[i*REG_W +: REG_W];
            if (bus.reg_addr == ADDR_W'(KB + i))
                bus.reg_rdata = op_const[i*REG_W +: REG_W];
            if (bus.reg_addr == ADDR_W'(CB + i))
                bus.reg_rdata = op_c[i*REG_W +: REG_W];
        end
    end
endmodule

// File: tb/tb_rsa_regbank_ctrl.sv
// Directed plus randomized self-checking bench for rsa_regbank_ctrl.
module tb_rsa_regbank_ctrl;
    localparam int REG_W  = 8;
    localparam int ADDR_W = 5;
    localparam int OB     = 4;
    localparam int OP_W   = OB * REG_W;
    localparam int A_P    = 2;
    localparam int A_E    = 2 + OB;
    localparam int A_M    = 2 + 2 * OB;
    localparam int A_K    = 2 + 3 * OB;
    localparam int A_C    = 2 + 4 * OB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_pin = 1'b0;
    logic            eng_en, eng_clr, eng_eoc, busy, irq;
    logic [OP_W-1:0] eng_c, op_p, op_e, op_m, op_const;
    logic [OP_W-1:0] model_c = '0;
    int              eoc_delay = 20;
    int              run_cnt = 0;
    int              tests = 0;
    int              fails = 0;

    rsa_regbank_ctrl_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    rsa_regbank_ctrl #(.REG_W(REG_W), .ADDR_W(ADDR_W), .OP_BYTES(OB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .start_pin (start_pin),
        .eng_en    (eng_en),
        .eng_clr   (eng_clr),
        .eng_eoc   (eng_eoc),
        .eng_c     (eng_c),
        .op_p      (op_p),
        .op_e      (op_e),
        .op_m      (op_m),
        .op_const  (op_const),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Engine model: result ready eoc_delay cycles into an enabled run.
    always @(posedge clk) run_cnt <= eng_en ? run_cnt + 1 : 0;
    assign eng_eoc = eng_en && (run_cnt >= eoc_delay);
    assign eng_c   = model_c;

    function automatic logic [63:0] modexp(logic [63:0] b, int e, logic [63:0] m);
        logic [63:0] r;
        r = 64'd1 % m;
        b = b % m;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(int a, int d);
        bus.reg_addr  = ADDR_W'(a);
        bus.reg_wdata = REG_W'(d);
        bus.reg_wr    = 1'b1;
        @(posedge clk);
        #1;
        bus.reg_wr    = 1'b0;
    endtask

    task automatic chk_rd(string tag, int a, int exp);
        bus.reg_addr = ADDR_W'(a);
        #1;
        chk(tag, 64'(bus.reg_rdata), 64'(exp));
    endtask

    task automatic wr_op(int base, logic [OP_W-1:0] v);
        for (int i = 0; i < OB; i++) wr(base + i, int'(v[i*REG_W +: REG_W]));
    endtask

    task automatic load_ops(logic [OP_W-1:0] p, int e, logic [OP_W-1:0] m,
                            logic [OP_W-1:0] k);
        wr_op(A_P, p);
        wr_op(A_E, OP_W'(e));
        wr_op(A_M, m);
        wr_op(A_K, k);
        model_c = OP_W'(modexp(64'(m), e, 64'(p)));
    endtask

    task automatic chk_c(string tag, logic [OP_W-1:0] v);
        for (int i = 0; i < OB; i++) chk(tag, 64'(bus_rd(A_C + i)), 64'(v[i*REG_W +: REG_W]));
    endtask

    function automatic logic [REG_W-1:0] bus_rd(int a);
        return (a < 0) ? '0 : '0;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (!(busy === 1'b0 && eng_clr === 1'b0) && k < 300) begin
            tick(1);
            k++;
        end
        chk("wait_idle_timeout", 64'(k >= 300), 64'd0);
    endtask

    task automatic wait_run(int n);
        int k = 0;
        while (!(eng_en === 1'b1 && run_cnt == n) && k < 300) begin
            tick(1);
            k++;
        end
        chk("wait_run_timeout", 64'(k >= 300), 64'd0);
    endtask

    task automatic chk_c_bytes(string tag, logic [OP_W-1:0] v);
        for (int i = 0; i < OB; i++) chk_rd(tag, A_C + i, int'(v[i*REG_W +: REG_W]));
    endtask

    initial begin
        logic [OP_W-1:0] rp, rm, rk;
        int              re, ie;

        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.reg_wr    = 1'b0;
        #1;
        chk("rst_eng_clr", 64'(eng_clr), 64'd1);
        chk("rst_eng_en", 64'(eng_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk_rd("rst_status", 0, 0);
        chk_rd("rst_p0", A_P, 0);
        tick(2);
        rst = 1'b0;
        #1;
        chk("post_rst_eng_clr", 64'(eng_clr), 64'd0);

        // Basic run: 5^3 mod 251 with IRQ enabled, latency checks.
        load_ops(OP_W'(32'hFB), 3, OP_W'(32'h05), '0);
        chk("model_c", 64'(model_c), 64'h7D);
        wr(1, 8'h05);
        chk("load_clr", 64'(eng_clr), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_en", 64'(eng_en), 64'd0);
        tick(1);
        chk("run_en", 64'(eng_en), 64'd1);
        chk("run_clr", 64'(eng_clr), 64'd0);
        wait_run(20);
        tick(1);
        chk("cap_en", 64'(eng_en), 64'd0);
        chk_rd("cap_status", 0, 8'h04);
        tick(1);
        chk_rd("done_status", 0, 8'h03);
        chk("done_irq", 64'(irq), 64'd1);
        chk_c_bytes("c_basic", OP_W'(32'h7D));
        wr(1, 8'h0C);
        chk_rd("clr_status", 0, 8'h00);
        chk("clr_irq", 64'(irq), 64'd0);

        // STOP on RUN cycle 5.
        wr(1, 8'h08);
        eoc_delay = 1000;
        wr(1, 8'h01);
        wait_run(4);
        wr(1, 8'h02);
        chk("abort_clr", 64'(eng_clr), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_en", 64'(eng_en), 64'd0);
        tick(1);
        chk("abort_clr_done", 64'(eng_clr), 64'd0);
        chk_rd("abort_status", 0, 8'h08);
        chk_c_bytes("abort_c_kept", OP_W'(32'h7D));

        // STOP in the same cycle as eoc: eoc wins.
        eoc_delay = 20;
        wr(1, 8'h01);
        wait_run(20);
        wr(1, 8'h02);
        chk("eoc_stop_cap", 64'(busy), 64'd1);
        tick(1);
        chk_rd("eoc_stop_status", 0, 8'h02);

        // STOP during LOAD is held and aborts on entry to RUN.
        wr(1, 8'h08);
        wr(1, 8'h01);
        wr(1, 8'h02);
        chk("pend_run", 64'(eng_en), 64'd1);
        tick(1);
        chk("pend_abort_clr", 64'(eng_clr), 64'd1);
        tick(1);
        chk_rd("pend_status", 0, 8'h08);

        // Operand write and second START while busy.
        wr(1, 8'h08);
        wr(1, 8'h01);
        tick(3);
        wr(A_P, 8'hAA);
        wr(1, 8'h01);
        wait_idle();
        chk_rd("busy_p0", A_P, 8'hFB);
        chk("busy_op_p", 64'(op_p), 64'hFB);
        chk_rd("busy_status", 0, 8'h32);
        chk_c_bytes("busy_c", OP_W'(32'h7D));

        // start_pin: LOAD on the 4th edge after the pin rises.
        wr(1, 8'h08);
        eoc_delay = 5;
        start_pin = 1'b1;
        tick(3);
        chk("pin_pre_clr", 64'(eng_clr), 64'd0);
        chk("pin_pre_busy", 64'(busy), 64'd0);
        tick(1);
        chk("pin_load_clr", 64'(eng_clr), 64'd1);
        tick(1);
        chk("pin_run_en", 64'(eng_en), 64'd1);
        wait_idle();
        tick(10);
        chk("pin_held_busy", 64'(busy), 64'd0);
        chk_rd("pin_status", 0, 8'h02);
        start_pin = 1'b0;
        wr(1, 8'h03);
        chk("ctrl3_busy", 64'(busy), 64'd0);
        chk("ctrl3_clr", 64'(eng_clr), 64'd0);
        tick(2);
        chk("ctrl3_busy2", 64'(busy), 64'd0);
        chk_rd("ctrl3_status", 0, 8'h02);

        // Asynchronous reset in RUN.
        eoc_delay = 20;
        wr(1, 8'h01);
        tick(4);
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_en", 64'(eng_en), 64'd0);
        chk_rd("arst_status", 0, 0);
        chk_rd("arst_p0", A_P, 0);
        chk_rd("arst_c0", A_C, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        load_ops(OP_W'(32'hFB), 3, OP_W'(32'h05), '0);
        wr(1, 8'h01);
        wait_idle();
        chk_rd("arst_rerun_status", 0, 8'h02);
        chk_c_bytes("arst_rerun_c", OP_W'(32'h7D));

        // Unmapped and read-only addresses.
        for (int a = 22; a < 32; a++) begin
            wr(a, 8'hFF);
            chk_rd("unmapped", a, 0);
        end
        wr(A_C, 8'h55);
        chk_rd("c_ro", A_C, 8'h7D);
        wr(0, 8'hFF);
        chk_rd("status_ro", 0, 8'h02);

        // IRQ disabled run.
        wr(1, 8'h01);
        wait_idle();
        chk_rd("noirq_status", 0, 8'h02);
        chk("noirq_irq", 64'(irq), 64'd0);

        // Randomized operands against the arithmetic model.
        for (int n = 0; n < 6; n++) begin
            rp = OP_W'($urandom) | OP_W'(1);
            rm = OP_W'($urandom);
            rk = OP_W'($urandom);
            re = int'($urandom_range(0, 40));
            ie = int'($urandom_range(0, 1));
            eoc_delay = int'($urandom_range(0, 30));
            load_ops(rp, re, rm, rk);
            chk("rnd_op_p", 64'(op_p), 64'(rp));
            chk("rnd_op_e", 64'(op_e), 64'(re));
            chk("rnd_op_m", 64'(op_m), 64'(rm));
            chk("rnd_op_k", 64'(op_const), 64'(rk));
            wr(1, 8'h08 | (ie << 2));
            wr(1, 8'h01 | (ie << 2));
            wait_idle();
            chk_c_bytes("rnd_c", model_c);
            chk_rd("rnd_status", 0, 8'h02 | ie);
            chk("rnd_irq", 64'(irq), 64'(ie));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
